// File: rtl/im_loader.sv
// im_loader -- boot-time instruction-memory loader.
//
// Accepts a byte stream, packs bytes big-endian into 32-bit words and writes
// each word to consecutive word addresses of the instruction memory through a
// registered write port. The CPU fetch stage is held until an image has been
// completely written.
//
// Optional feature macro: IM_LOADER_CHECKSUM_EN
//   defined   -> checksum accumulates the sum of written words (mod 2^32)
//   undefined -> no accumulator, checksum is tied to 0
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle pulse: begin (or restart) a load at address 0
//   in_valid/in_ready byte stream handshake, in_data byte, in_last final byte
//   im_we/im_addr/im_wdata  registered instruction-memory write port
//   cpu_hold          holds CPU fetch while high (IDLE and LOAD)
//   done              image complete (level, DONE state)
//   overflow          image exceeded DEPTH words
//   words_written     words written in the current load
//   checksum          running sum of written words
//   state_dbg         current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready never depends on in_valid; a producer holding
// in_valid while in_ready is 0 keeps its byte, nothing is dropped.
module im_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65534
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_written,
  output logic [31:0]       checksum,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [23:0]       shift_q;     // up to three earlier bytes of the current word
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] wr_addr;     // address the next word will be written to
  // Set when the final word of the image is written; the FSM leaves LOAD one
  // cycle later so done rises the cycle after that write.
  logic              fin_pending;
  logic              ovf_pending;

  logic        restart;
  logic        accept;
  logic        word_write;
  logic        finish;
  logic        at_last_addr;
  logic [31:0] word_full;
  logic [31:0] word_out;
  logic [4:0]  fill_sh;

  always_comb begin
    restart      = start && (state != ST_LOAD);
    in_ready     = (state == ST_LOAD) && !fin_pending;
    accept       = in_valid && in_ready;
    word_write   = accept && ((byte_idx == 2'd3) || in_last);
    finish       = (state == ST_LOAD) && fin_pending;
    at_last_addr = (wr_addr == ADDR_W'(DEPTH - 1));
    word_full    = {shift_q, in_data};
    // A short final word is left-aligned; missing low bytes become zero.
    fill_sh      = {2'd3 - byte_idx, 3'b000};
    word_out     = word_full << fill_sh;
    done         = (state == ST_DONE);
    cpu_hold     = (state != ST_DONE);
    state_dbg    = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)  state_next = ST_LOAD;
      ST_LOAD: if (finish) state_next = ST_DONE;
      ST_DONE: if (start)  state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_we         <= 1'b0;
      im_addr       <= '0;
      im_wdata      <= '0;
      words_written <= '0;
      overflow      <= 1'b0;
      shift_q       <= '0;
      byte_idx      <= '0;
      wr_addr       <= '0;
      fin_pending   <= 1'b0;
      ovf_pending   <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (restart) begin
        im_addr       <= '0;
        words_written <= '0;
        overflow      <= 1'b0;
        shift_q       <= '0;
        byte_idx      <= '0;
        wr_addr       <= '0;
        fin_pending   <= 1'b0;
        ovf_pending   <= 1'b0;
      end else if (word_write) begin
        im_we         <= 1'b1;
        im_addr       <= wr_addr;
        im_wdata      <= word_out;
        wr_addr       <= wr_addr + ADDR_W'(1);
        words_written <= words_written + (ADDR_W + 1)'(1);
        shift_q       <= '0;
        byte_idx      <= '0;
        if (in_last) begin
          fin_pending <= 1'b1;
        end else if (at_last_addr) begin
          // Memory full before the image ended: stop without wrapping.
          fin_pending <= 1'b1;
          ovf_pending <= 1'b1;
        end
      end else if (accept) begin
        shift_q  <= word_full[23:0];
        byte_idx <= byte_idx + 2'd1;
      end

      if (finish) begin
        overflow    <= ovf_pending;
        fin_pending <= 1'b0;
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           checksum_q <= '0;
    else if (restart)    checksum_q <= '0;
    else if (word_write) checksum_q <= checksum_q + word_out;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Directed testbench for im_loader (DEPTH = 4 so the full-memory case is short).
module tb_im_loader;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   words_written;
  logic [31:0]       checksum;
  logic [1:0]        state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected writes, {addr, data}, in order.
  logic [47:0] exp_q[$];

  im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
    .words_written(words_written), .checksum(checksum), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cs(input logic [31:0] v);
`ifdef IM_LOADER_CHECKSUM_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_q.push_back({16'(addr), data});
  endtask

  // One clock: advance past the edge, then check any write against the queue.
  task automatic tick();
    logic [47:0] e;
    @(posedge clk);
    #1;
    if (im_we !== 1'b0) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", im_addr, im_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {im_addr, im_wdata}, e);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic last,
                           input logic expect_we, input logic gap);
    int waited;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("we_after_byte", im_we, expect_we);
    if (gap) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_words"}, words_written, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Two-word image 3C011234, 00000008.
    pulse_start();
    chk("start_ready", in_ready, 1);
    chk("start_state", state_dbg, 1);
    push_exp(0, 32'h3C011234);
    push_exp(1, 32'h00000008);
    send_byte(8'h3C, 0, 0, 0);
    send_byte(8'h01, 0, 0, 0);
    send_byte(8'h12, 0, 0, 0);
    send_byte(8'h34, 0, 1, 0);
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'h08, 1, 1, 0);
    chk("img1_done_not_yet", done, 0);
    chk("img1_ready_after_last", in_ready, 0);
    tick();
    chk("img1_done", done, 1);
    chk("img1_cpu_hold", cpu_hold, 0);
    chk("img1_ready", in_ready, 0);
    chk("img1_words", words_written, 2);
    chk("img1_checksum", checksum, cs(32'h3C01123C));
    chk("img1_overflow", overflow, 0);

    // Restart from DONE; partial final word; start ignored mid-load.
    pulse_start();
    chk("img2_words_cleared", words_written, 0);
    chk("img2_done_cleared", done, 0);
    chk("img2_cpu_hold", cpu_hold, 1);
    chk("img2_checksum_cleared", checksum, 0);
    push_exp(0, 32'h11223344);
    push_exp(1, 32'h55000000);
    send_byte(8'h11, 0, 0, 0);
    send_byte(8'h22, 0, 0, 0);
    pulse_start();
    chk("img2_start_ignored", state_dbg, 1);
    send_byte(8'h33, 0, 0, 0);
    send_byte(8'h44, 0, 1, 0);
    send_byte(8'h55, 1, 1, 0);
    tick();
    chk("img2_done", done, 1);
    chk("img2_words", words_written, 2);
    chk("img2_checksum", checksum, cs(32'h66223344));

    // in_valid on every other cycle.
    pulse_start();
    push_exp(0, 32'hDEADBEEF);
    push_exp(1, 32'h01020304);
    send_byte(8'hDE, 0, 0, 1);
    send_byte(8'hAD, 0, 0, 1);
    send_byte(8'hBE, 0, 0, 1);
    send_byte(8'hEF, 0, 1, 1);
    send_byte(8'h01, 0, 0, 1);
    send_byte(8'h02, 0, 0, 1);
    send_byte(8'h03, 0, 0, 1);
    send_byte(8'h04, 1, 1, 1);
    chk("img3_done", done, 1);
    chk("img3_words", words_written, 2);
    chk("img3_checksum", checksum, cs(32'hDFAFC1F3));

    // Full memory: 16 bytes fill DEPTH=4 words, no in_last.
    pulse_start();
    push_exp(0, 32'h00010203);
    push_exp(1, 32'h04050607);
    push_exp(2, 32'h08090A0B);
    push_exp(3, 32'h0C0D0E0F);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 0, (i % 4) == 3, 0);
    end
    chk("ovf_not_yet", overflow, 0);
    chk("ovf_ready_after_full", in_ready, 0);
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_done", done, 1);
    chk("ovf_words", words_written, 4);
    chk("ovf_addr_no_wrap", im_addr, 3);
    chk("ovf_checksum", checksum, cs(32'h181C2024));
    in_valid = 1'b1;
    in_data  = 8'h10;
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_ready_stays_low", in_ready, 0);
    chk("ovf_words_stable", words_written, 4);
    in_valid = 1'b0;

    // Reset in the middle of the second word.
    pulse_start();
    chk("img5_overflow_cleared", overflow, 0);
    push_exp(0, 32'hABCDEF01);
    send_byte(8'hAB, 0, 0, 0);
    send_byte(8'hCD, 0, 0, 0);
    send_byte(8'hEF, 0, 0, 0);
    send_byte(8'h01, 0, 1, 0);
    send_byte(8'h02, 0, 0, 0);
    send_byte(8'h03, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_state", state_dbg, 0);
    chk("post_rst_cpu_hold", cpu_hold, 1);
    chk("post_rst_words", words_written, 0);
    chk("all_writes_seen", 48'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader for the instruction memory. It accepts a byte stream through a valid/ready handshake and assembles the bytes big-endian into 32-bit instructions. Each instruction is written into consecutive word-indexed instruction-memory locations through a registered write port. While loading, it holds the CPU fetch stage, so the processor starts executing only after a complete image is in place.

## Interface
Parameters:
- `ADDR_W`, 16: width of the word address into instruction memory.
- `DEPTH`, 65534: number of writable words; valid addresses are 0..DEPTH-1.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle pulse that begins a load at address 0.
- `in_valid`, input, 1: `in_data` carries a byte.
- `in_data`, input, 8: stream byte; the first byte of each word is bits [31:24].
- `in_last`, input, 1: qualifies the final byte of the image.
- `in_ready`, output, 1: the loader accepts a byte this cycle.
- `im_we`, output, 1: instruction-memory write enable, registered.
- `im_addr`, output, ADDR_W: word address of the write.
- `im_wdata`, output, 32: instruction word being written.
- `cpu_hold`, output, 1: stalls the fetch stage while it is high.
- `done`, output, 1: the image is completely written (level signal).
- `overflow`, output, 1: the image exceeded DEPTH words.
- `words_written`, output, ADDR_W+1: count of words written in this load.
- `checksum`, output, 32: running sum of the written words (see Configuration).

## Operation
- States are IDLE, LOAD and DONE.
- Reset values:
  - State goes to IDLE.
  - `in_ready`, `im_we`, `done` and `overflow` are 0.
  - `im_addr`, `im_wdata`, `words_written` and `checksum` are 0.
  - `cpu_hold` is 1; the CPU is held until the first load finishes.
  - The byte index (0..3) and the word shift register are 0.
- Transitions:
  - IDLE to LOAD on `start`.
  - DONE to LOAD on `start`. This restarts the load: address, count, checksum, byte index and `overflow` are cleared, and `done` is cleared.
  - `start` while in LOAD is ignored.
- In LOAD, `in_ready` is 1. A byte is accepted when `in_valid` and `in_ready` are both 1 on a clock edge.
  - The byte shifts into the word register and the byte index increments.
  - On the 4th byte (index 3), the completed word is registered to `im_wdata`/`im_addr`, `im_we` is pulsed, and the index wraps to 0.
- Partial final word: if `in_last` arrives with index less than 3, the remaining low bytes are zero-filled and the word is written.
  - Example: the bytes AA BB with `in_last` produce 0xAABB0000.
- After each write:
  - The address increments by 1.
  - `words_written` increments by 1.
  - `checksum` adds the word, wrapping at 32 bits.
- Full: when the word is written at DEPTH-1 and `in_last` was not set, `overflow` is set to 1 and the state goes to DONE. No further writes occur; the address never wraps.
- In DONE: `in_ready` is 0, `done` is 1, `cpu_hold` is 0, and `im_we` is 0.
- A reset mid-load aborts immediately to the reset values. A partial word is discarded.

## Timing
- Byte accept at cycle N that completes a word: `im_we` is 1 during cycle N+1, with `im_addr`/`im_wdata` valid in that cycle.
- `im_we` is high for exactly one cycle per word.
- Last byte accepted at cycle N:
  - Write at N+1.
  - State is DONE at N+2, where `done` rises and `cpu_hold` falls.
- Back-to-back bytes every cycle are sustained without stalls. Peak throughput is one word per 4 cycles.
- `start` at cycle N puts the loader in LOAD at N+1, so `in_ready` is 1 from N+1.
- `in_valid` without `in_ready` drops no data. The producer must hold the byte.

## Configuration
- `IM_LOADER_CHECKSUM_EN`
  - Defined: `checksum` accumulates as described above.
  - Undefined: the accumulator is not synthesized and `checksum` is constant 0. All other behaviour is identical.

## Test plan
- Reset, then `start`, then the 8 bytes 3C 01 12 34 00 00 00 08 with `in_last` on the 8th byte:
  - Writes 0x3C011234 at address 0 and 0x00000008 at address 1.
  - `words_written`=2, `done`=1, `cpu_hold`=0.
  - `checksum`=0x3C01123C when the macro is defined, 0 when it is not.
- 5 bytes 11 22 33 44 55 with `in_last` on 55: writes 0x11223344 at address 0, then 0x55000000 at address 1.
- With DEPTH=4, stream 20 bytes and no `in_last`:
  - 4 writes at addresses 0..3, then `overflow`=1 and `done`=1.
  - `in_ready` is 0 afterwards, and the 17th byte is never written.
- `in_valid` toggling every other cycle: each word's write comes one cycle after its 4th accepted byte, and the data is unchanged.
- Assert `reset` after 2 bytes of the second word:
  - All outputs return to reset values at once, with `cpu_hold`=1.
  - No write of the partial word occurs.
- `start` pulsed during LOAD is ignored. `start` pulsed in DONE restarts the load at address 0 with `words_written`=0.
